// File: rtl/polynomial_pkg.sv
// -----------------------------------------------------------------------------
// polynomial_pkg
//   Shared definitions for the Polynomial3 coefficient channel.
//   - POLY_SEL_*   : field-select codes used by the legacy staging write bus.
//   - POLY_*_W     : field widths of the Polynomial3 record.
//   - Polynomial3  : the packed record carried on the ESI channel, matching the
//                    shared schema (a: 32-bit, b: 5-bit, c: 8-bit, unsigned).
// -----------------------------------------------------------------------------
package polynomial_pkg;

  localparam logic [1:0] POLY_SEL_A    = 2'd0;
  localparam logic [1:0] POLY_SEL_B    = 2'd1;
  localparam logic [1:0] POLY_SEL_C    = 2'd2;
  localparam logic [1:0] POLY_SEL_RSVD = 2'd3;

  localparam int POLY_A_W = 32;
  localparam int POLY_B_W = 5;
  localparam int POLY_C_W = 8;

  typedef struct packed {
    logic [POLY_A_W-1:0] a;
    logic [POLY_B_W-1:0] b;
    logic [POLY_C_W-1:0] c;
  } Polynomial3;

endpackage

// File: rtl/ipolynomial3_valid_ready.sv
// -----------------------------------------------------------------------------
// IPolynomial3ValidReady
//   ESI valid/ready channel carrying one Polynomial3 per transfer.
//   A transfer happens on any clock edge where valid && ready.
//   Modports:
//     Source : drives valid and data, observes ready.
//     Sink   : observes valid and data, drives ready.
// -----------------------------------------------------------------------------
interface IPolynomial3ValidReady;
  import polynomial_pkg::*;

  logic       valid;
  logic       ready;
  Polynomial3 data;

  modport Source (output valid, output data, input ready);
  modport Sink   (input valid, input data, output ready);

endinterface

// File: rtl/esi_sync_fifo.sv
// -----------------------------------------------------------------------------
// esi_sync_fifo
//   Single-clock FIFO intended to sit behind an ESI valid/ready source.
//   Pointers carry one extra wrap bit so full and empty are distinguished
//   without a separate counter. The head entry is presented combinationally
//   from registered state only (no path from push to head/empty).
//
//   Parameters:
//     T      : entry type (any packed type)
//     DEPTH  : number of entries, power of two, >= 2
//   Ports:
//     clk        : clock, posedge
//     rst        : asynchronous active-high reset
//     push       : write push_data this cycle (ignored when full unless popping)
//     push_data  : entry to write
//     pop        : remove the head entry this cycle (ignored when empty)
//     head       : current head entry, zero while empty
//     level      : current occupancy, 0..DEPTH
//     full       : level == DEPTH
//     empty      : level == 0
// -----------------------------------------------------------------------------
module esi_sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  output T                           head,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(DEPTH+1);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  T              mem [DEPTH];

  logic do_push;
  logic do_pop;

  // Full: same slot index but the wrap bits differ (writer is one lap ahead).
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = LW'(wr_ptr - rd_ptr);

  // A push into a full FIFO is still legal when the head leaves on the same
  // edge: the freed slot is exactly the one the write pointer lands on.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // NOTE: the storage array is deliberately not reset; only the pointers are.
  // Stale entries are unreachable after reset because the FIFO reads empty,
  // and head is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head = empty ? T'('0) : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/polynomial3_coeff_source.sv
// -----------------------------------------------------------------------------
// polynomial3_coeff_source
//   Producer end of the IPolynomial3ValidReady channel. Control logic writes
//   the a/b/c coefficients one field at a time into staging registers and then
//   commits; each commit snapshots the staged record into a small FIFO that
//   drains onto the ESI source toward a Polynomial3 compute sink.
//
//   Parameters:
//     DEPTH : FIFO entries, power of two, >= 2
//     WR_W  : width of the legacy write-data bus
//   Ports:
//     clk          : clock, posedge
//     rst          : asynchronous active-high reset
//     wr_en        : write the field chosen by wr_sel this cycle
//     wr_sel       : 0=a, 1=b, 2=c, 3=reserved (no effect)
//     wr_data      : field value, low-order bits used
//     commit       : push the staged {a,b,c} (including a same-cycle write)
//     clr_overflow : clear the sticky overflow flag (a same-cycle drop wins)
//     abc          : ESI source (valid/data out, ready in)
//     level        : FIFO occupancy
//     full         : level == DEPTH
//     overflow     : sticky, a commit was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module polynomial3_coeff_source
  import polynomial_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WR_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [1:0]                  wr_sel,
  input  logic [WR_W-1:0]             wr_data,
  input  logic                        commit,
  input  logic                        clr_overflow,
  IPolynomial3ValidReady.Source       abc,
  output logic [$clog2(DEPTH+1)-1:0]  level,
  output logic                        full,
  output logic                        overflow
);

  // Widen the write bus so every field can take its low bits even when WR_W
  // is narrower than a field; the extra top bit keeps the discarded slice
  // non-empty for any WR_W.
  localparam int EXT_W = (WR_W > POLY_A_W) ? WR_W : POLY_A_W + 1;

  logic [EXT_W-1:0] wr_ext;
  logic             unused_wr_bits;

  assign wr_ext         = EXT_W'(wr_data);
  assign unused_wr_bits = ^wr_ext[EXT_W-1:POLY_A_W];

  Polynomial3 staged;
  Polynomial3 push_data;

  logic                       fifo_full;
  logic                       fifo_empty;
  logic [$clog2(DEPTH+1)-1:0] fifo_level;
  Polynomial3                 fifo_head;

  logic fifo_valid;
  logic pop;
  logic push_ok;
  logic drop;

  // Write-through bypass: the record pushed on a commit already carries a
  // field written in the same cycle. The same value is what the staging
  // registers load, so one mux serves both.
  // NOTE: every always_comb output gets its default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    push_data = staged;
    if (wr_en) begin
      unique case (wr_sel)
        POLY_SEL_A: push_data.a = wr_ext[POLY_A_W-1:0];
        POLY_SEL_B: push_data.b = wr_ext[POLY_B_W-1:0];
        POLY_SEL_C: push_data.c = wr_ext[POLY_C_W-1:0];
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      staged <= '0;
    end else if (wr_en && (wr_sel != POLY_SEL_RSVD)) begin
      staged <= push_data;
    end
  end

  // Valid comes only from FIFO occupancy, so commit never reaches valid
  // combinationally; ready is meaningless while nothing is offered.
  assign fifo_valid = !fifo_empty;
  assign pop        = fifo_valid && abc.ready;

  // A commit into a full FIFO survives only if the head leaves this edge.
  assign push_ok = commit && (!fifo_full || pop);
  assign drop    = commit && fifo_full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

  esi_sync_fifo #(
    .T     (Polynomial3),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_ok),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign abc.valid = fifo_valid;
  assign abc.data  = fifo_head;
  assign level     = fifo_level;
  assign full      = fifo_full;

endmodule

// File: tb/tb_polynomial3_coeff_source.sv
// -----------------------------------------------------------------------------
// tb_polynomial3_coeff_source
//   Self-checking bench for polynomial3_coeff_source. A queue-based model of
//   the coefficient source is updated on each clock edge; a compare process
//   checks valid/level/full/overflow/data against it on every falling edge,
//   checks that a stalled offer stays stable, and logs what the sink accepted.
//   Directed sequences then pin the model with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_polynomial3_coeff_source;
  import polynomial_pkg::*;

  localparam int DEPTH = 4;
  localparam int WR_W  = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [1:0]       wr_sel;
  logic [WR_W-1:0]  wr_data;
  logic             commit;
  logic             clr_overflow;
  logic [2:0]       level;
  logic             full;
  logic             overflow;

  IPolynomial3ValidReady abc_if ();

  polynomial3_coeff_source #(
    .DEPTH (DEPTH),
    .WR_W  (WR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_sel       (wr_sel),
    .wr_data      (wr_data),
    .commit       (commit),
    .clr_overflow (clr_overflow),
    .abc          (abc_if),
    .level        (level),
    .full         (full),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic Polynomial3 mk(input int a, input int b, input int c);
    Polynomial3 p;
    p.a = 32'(a);
    p.b = 5'(b);
    p.c = 8'(c);
    return p;
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model: a queue of pending records, the staged record and the
  // sticky flag, advanced once per rising edge from the sampled inputs.
  // ---------------------------------------------------------------------------
  Polynomial3 mq[$];
  Polynomial3 m_stage;
  Polynomial3 m_next;
  bit         m_ovf;
  bit         m_popped;
  bit         m_drop;
  int         m_occ;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_stage = '0;
      m_ovf   = 1'b0;
    end else begin
      m_occ    = mq.size();
      m_popped = (m_occ > 0) && abc_if.ready;
      m_next   = m_stage;
      if (wr_en) begin
        case (wr_sel)
          2'd0: m_next.a = 32'(wr_data);
          2'd1: m_next.b = 5'(wr_data % 32);
          2'd2: m_next.c = 8'(wr_data % 256);
          default: ;
        endcase
      end
      m_drop = commit && (m_occ == DEPTH) && !m_popped;
      if (m_popped) void'(mq.pop_front());
      if (commit && !m_drop) mq.push_back(m_next);
      if (m_drop) m_ovf = 1'b1;
      else if (clr_overflow) m_ovf = 1'b0;
      m_stage = m_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process and sink log.
  // ---------------------------------------------------------------------------
  bit         cmp_en = 1'b0;
  bit         stall_prev = 1'b0;
  Polynomial3 stall_data;
  Polynomial3 rx[$];

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else if (cmp_en) begin
      check("valid", 64'(abc_if.valid), 64'(mq.size() != 0));
      check("level", 64'(level), 64'(mq.size()));
      check("full", 64'(full), 64'(mq.size() == DEPTH));
      check("overflow", 64'(overflow), 64'(m_ovf));
      if (mq.size() != 0) check("data", 64'(abc_if.data), 64'(mq[0]));
      if (stall_prev) begin
        check("stall_valid", 64'(abc_if.valid), 64'(1));
        check("stall_data", 64'(abc_if.data), 64'(stall_data));
      end
      stall_prev = abc_if.valid && !abc_if.ready;
      stall_data = abc_if.data;
      if (abc_if.valid && abc_if.ready) rx.push_back(abc_if.data);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] s, input logic [WR_W-1:0] d, input bit with_commit);
    wr_en   = 1'b1;
    wr_sel  = s;
    wr_data = d;
    commit  = with_commit;
    step();
    wr_en   = 1'b0;
    commit  = 1'b0;
  endtask

  task automatic set_abc(input int a, input int b, input int c);
    wr(2'd0, 32'(a), 1'b0);
    wr(2'd1, 32'(b), 1'b0);
    wr(2'd2, 32'(c), 1'b0);
  endtask

  task automatic do_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  logic [31:0] ready_pat = 32'b1011_0010_1101_0110_0111_0001_1010_1101;
  int          cyc;
  int          guard;

  initial begin
    rst          = 1'b1;
    wr_en        = 1'b0;
    wr_sel       = 2'd0;
    wr_data      = '0;
    commit       = 1'b0;
    clr_overflow = 1'b0;
    abc_if.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    check("rst_valid", 64'(abc_if.valid), 64'(0));
    check("rst_level", 64'(level), 64'(0));
    check("rst_full", 64'(full), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    check("rst_data", 64'(abc_if.data), 64'(0));
    cmp_en = 1'b1;

    // 1: single record, one-cycle latency, no combinational commit->valid.
    abc_if.ready = 1'b1;
    set_abc(3, 5, 7);
    rx.delete();
    commit = 1'b1;
    #1;
    check("t1_no_comb_path", 64'(abc_if.valid), 64'(0));
    @(posedge clk);
    #1;
    commit = 1'b0;
    check("t1_valid_after_commit", 64'(abc_if.valid), 64'(1));
    check("t1_data", 64'(abc_if.data), 64'(mk(3, 5, 7)));
    step();
    check("t1_level_back_to_0", 64'(level), 64'(0));
    check("t1_rx_count", 64'(rx.size()), 64'(1));
    if (rx.size() >= 1) check("t1_rx0", 64'(rx[0]), 64'(mk(3, 5, 7)));

    // 2: fill under stall, drop on fifth commit, then drain in order.
    abc_if.ready = 1'b0;
    rx.delete();
    for (int i = 1; i <= 4; i++) begin
      set_abc(i, i, i);
      do_commit();
    end
    check("t2_level_full", 64'(level), 64'(4));
    check("t2_full", 64'(full), 64'(1));
    check("t2_head_held", 64'(abc_if.data), 64'(mk(1, 1, 1)));
    set_abc(5, 5, 5);
    do_commit();
    check("t2_overflow_set", 64'(overflow), 64'(1));
    check("t2_level_kept", 64'(level), 64'(4));
    abc_if.ready = 1'b1;
    repeat (4) step();
    abc_if.ready = 1'b0;
    check("t2_rx_count", 64'(rx.size()), 64'(4));
    for (int k = 0; k < 4 && k < rx.size(); k++)
      check("t2_rx_order", 64'(rx[k]), 64'(mk(k + 1, k + 1, k + 1)));
    check("t2_overflow_sticky", 64'(overflow), 64'(1));
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    check("t2_overflow_cleared", 64'(overflow), 64'(0));

    // 3: drop and clear together (set wins), then push while full and popping.
    rx.delete();
    for (int i = 1; i <= 4; i++) wr(2'd0, 32'(i), 1'b1);
    check("t3_full", 64'(full), 64'(1));
    commit       = 1'b1;
    clr_overflow = 1'b1;
    step();
    commit       = 1'b0;
    clr_overflow = 1'b0;
    check("t3_set_wins", 64'(overflow), 64'(1));
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    check("t3_clear", 64'(overflow), 64'(0));
    wr(2'd1, 32'd9, 1'b0);
    wr(2'd2, 32'd9, 1'b0);
    abc_if.ready = 1'b1;
    wr(2'd0, 32'd9, 1'b1);
    abc_if.ready = 1'b0;
    check("t3_level_stays_4", 64'(level), 64'(4));
    check("t3_no_overflow", 64'(overflow), 64'(0));
    abc_if.ready = 1'b1;
    repeat (4) step();
    check("t3_rx_count", 64'(rx.size()), 64'(5));
    if (rx.size() == 5) begin
      check("t3_rx_first", 64'(rx[0]), 64'(mk(1, 5, 5)));
      check("t3_rx_last", 64'(rx[4]), 64'(mk(9, 9, 9)));
    end

    // 4: bypass truncation on b, reserved select has no effect.
    rx.delete();
    wr(2'd1, 32'h0001_2345, 1'b1);
    repeat (2) step();
    wr(2'd3, 32'h0000_00FF, 1'b1);
    repeat (2) step();
    check("t4_rx_count", 64'(rx.size()), 64'(2));
    if (rx.size() == 2) begin
      check("t4_bypass_b", 64'(rx[0]), 64'(mk(9, 5, 9)));
      check("t4_rsvd_noop", 64'(rx[1]), 64'(mk(9, 5, 9)));
    end

    // 5: 12 commits with a toggling sink (pointer wrap, stall stability).
    rx.delete();
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      guard = 0;
      while (mq.size() == DEPTH && guard < 50) begin
        abc_if.ready = 1'b1;
        step();
        guard++;
      end
      abc_if.ready = ready_pat[cyc % 32];
      cyc++;
      wr(2'd0, 32'(100 + i), 1'b1);
      abc_if.ready = ready_pat[cyc % 32];
      cyc++;
      step();
    end
    abc_if.ready = 1'b1;
    repeat (8) step();
    check("t5_rx_count", 64'(rx.size()), 64'(12));
    for (int k = 0; k < 12 && k < rx.size(); k++)
      check("t5_rx_order", 64'(rx[k]), 64'(mk(100 + k, 5, 9)));
    check("t5_drained", 64'(level), 64'(0));

    // 6: asynchronous reset in the middle of a stall.
    abc_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) wr(2'd2, 32'(20 + i), 1'b1);
    check("t6_level_3", 64'(level), 64'(3));
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_valid", 64'(abc_if.valid), 64'(0));
    check("t6_async_level", 64'(level), 64'(0));
    check("t6_async_full", 64'(full), 64'(0));
    step();
    rst = 1'b0;
    rx.delete();
    abc_if.ready = 1'b1;
    do_commit();
    repeat (3) step();
    check("t6_rx_count", 64'(rx.size()), 64'(1));
    if (rx.size() == 1) check("t6_rx_zero", 64'(rx[0]), 64'(mk(0, 0, 0)));
    check("t6_level_0", 64'(level), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
